// File: rtl/dds_wave_gen.sv
// DDS waveform generator: 32-bit phase accumulator, 3-stage sample pipeline
// (phase index -> raw waveform -> amplitude scale) driving an 8-bit DAC.
module dds_wave_gen #(
  parameter int FTW_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] cnt_sig,
  input  logic [1:0] cnt_amp,
  input  logic [1:0] cnt_fre,
  input  logic [1:0] cnt_phase,
  input  logic       confirm,
  output logic [7:0] data_out,
  output logic       da_clk
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  // round(127.5*sin((2i+1)*pi/256)), first quarter of the sine period
  localparam logic [6:0] SINE_Q [64] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd36,  7'd39,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd59,  7'd61,  7'd64,  7'd67,  7'd70,
    7'd72,  7'd75,  7'd77,  7'd80,  7'd82,  7'd84,  7'd87,  7'd89,
    7'd91,  7'd93,  7'd96,  7'd98,  7'd100, 7'd101, 7'd103, 7'd105,
    7'd107, 7'd109, 7'd110, 7'd112, 7'd113, 7'd115, 7'd116, 7'd117,
    7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124, 7'd125,
    7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127
  };

  state_t           state, state_next;
  logic             confirm_prev;
  logic [1:0]       sig_sh, amp_sh, fre_sh, phase_sh;
  logic [FTW_W-1:0] acc, ftw;
  logic [7:0]       p, p_next;
  logic [7:0]       s, s_next;
  logic [7:0]       out_val;
  logic [2:0]       valid;

  logic [5:0]       q_idx;
  logic [6:0]       q_val;
  logic [7:0]       sine_val, tri_val, sq_val, duty;
  logic signed [8:0] d, scaled;

  assign da_clk = ~clk;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (confirm && !confirm_prev) state_next = LOAD;
      LOAD:    state_next = confirm ? RUN : IDLE;
      RUN:     if (!confirm) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (fre_sh)
      2'd0:    ftw = FTW_W'(85899);
      2'd1:    ftw = FTW_W'(858993);
      2'd2:    ftw = FTW_W'(8589935);
      default: ftw = FTW_W'(85899346);
    endcase
  end

  // Phase offset applies to every shape except square, where cnt_phase is duty
  assign p_next = acc[FTW_W-1 -: 8] + ((sig_sh != 2'd1) ? {phase_sh, 6'd0} : 8'd0);

  always_comb begin
    q_idx    = p[6] ? ~p[5:0] : p[5:0];
    q_val    = SINE_Q[q_idx];
    sine_val = p[7] ? (8'd127 - {1'b0, q_val}) : (8'd128 + {1'b0, q_val});
    tri_val  = p[7] ? 8'(9'd511 - {p, 1'b0}) : {p[6:0], 1'b0};
    case (phase_sh)
      2'd0:    duty = 8'd32;
      2'd1:    duty = 8'd64;
      2'd2:    duty = 8'd128;
      default: duty = 8'd192;
    endcase
    sq_val = (p < duty) ? 8'd255 : 8'd0;
    case (sig_sh)
      2'd0:    s_next = sine_val;
      2'd1:    s_next = sq_val;
      2'd2:    s_next = tri_val;
      default: s_next = p;
    endcase
  end

  always_comb begin
    d       = $signed({1'b0, s}) - 9'sd128;
    scaled  = d >>> amp_sh;
    out_val = 8'(scaled + 9'sd128);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      confirm_prev <= 1'b1;  // a confirm held across reset is not a fresh rise
      sig_sh       <= '0;
      amp_sh       <= '0;
      fre_sh       <= '0;
      phase_sh     <= '0;
      acc          <= '0;
      p            <= '0;
      s            <= '0;
      valid        <= '0;
      data_out     <= 8'd128;
    end else begin
      state        <= state_next;
      confirm_prev <= confirm;
      if (state == LOAD) begin
        sig_sh   <= cnt_sig;
        amp_sh   <= cnt_amp;
        fre_sh   <= cnt_fre;
        phase_sh <= cnt_phase;
      end
      acc <= (state == RUN) ? acc + ftw : '0;
      p   <= p_next;
      s   <= s_next;
      // Leaving RUN flushes the pipe so no stale sample reaches the DAC
      valid    <= (state == RUN) ? {valid[1:0], 1'b1} : 3'b000;
      data_out <= (state == RUN && valid[1]) ? out_val : 8'd128;
    end
  end

endmodule
